// File: rtl/reg32_load_sequencer_if.sv
// Bundle between the byte-stream front end / op requester and the FunSel register sequencer.
// The sequencer uses the slave modport; the requester side uses master.
interface reg32_load_sequencer_if;
  logic        Start;
  logic [1:0]  Len;
  logic        SignExt;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        OpReq;
  logic [1:0]  OpCode;
  logic        OpAck;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [31:0] RegI;
  logic        Busy;
  logic        Done;
  logic        Err;

  modport master (
    output Start, Len, SignExt, ByteIn, ByteValid, OpReq, OpCode,
    input  ByteReady, OpAck, RegE, RegFunSel, RegI, Busy, Done, Err
  );

  modport slave (
    input  Start, Len, SignExt, ByteIn, ByteValid, OpReq, OpCode,
    output ByteReady, OpAck, RegE, RegFunSel, RegI, Busy, Done, Err
  );
endinterface

// File: rtl/reg32_load_sequencer.sv
// Sequences a 32-bit FunSel register: big-endian 1..4 byte loads, sign-extended halfword
// loads and single inc/dec/clear ops. Optional stall timeout under REG_SEQ_TIMEOUT_EN.
module reg32_load_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        Clock,
  input  logic                        Reset,
  reg32_load_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LOAD  = 3'b100;
  localparam logic [2:0] FS_SHIFT = 3'b110;
  localparam logic [2:0] FS_SEXT  = 3'b111;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("reg32_load_sequencer: TIMEOUT must be in 1..255");
  end

  state_e      state_q, state_d;
  logic [1:0]  len_q, len_d;
  logic        sign_ext_q, sign_ext_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        last_start_q, last_start_d;
  logic        byte_ready_q, byte_ready_d;
  logic        op_ack_q, op_ack_d;
  logic        reg_e_q, reg_e_d;
  logic [2:0]  reg_fun_sel_q, reg_fun_sel_d;
  logic [31:0] reg_i_q, reg_i_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        grant_start;
  logic        grant_op;
  logic        accept;

`ifdef REG_SEQ_TIMEOUT_EN
  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] stall_q, stall_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sign_ext_d    = sign_ext_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    last_start_d  = last_start_q;
    byte_ready_d  = byte_ready_q;
    op_ack_d      = 1'b0;
    reg_e_d       = 1'b0;
    reg_fun_sel_d = reg_fun_sel_q;
    reg_i_d       = reg_i_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    grant_start   = 1'b0;
    grant_op      = 1'b0;
    accept        = bus.ByteValid & byte_ready_q;
`ifdef REG_SEQ_TIMEOUT_EN
    stall_d       = stall_q;
    err_d         = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // No arbitration while the previous grant's write is still on the bus.
        if (!op_ack_q && !reg_e_q) begin
          grant_start = bus.Start & (~bus.OpReq | ~last_start_q);
          grant_op    = bus.OpReq & ~grant_start;
        end
        if (grant_start) begin
          len_d        = bus.Len;
          sign_ext_d   = bus.SignExt & (bus.Len == 2'd1);
          cnt_d        = 2'd0;
          state_d      = ST_COLLECT;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          last_start_d = 1'b1;
`ifdef REG_SEQ_TIMEOUT_EN
          stall_d      = 8'd0;
`endif
        end else if (grant_op) begin
          op_ack_d     = 1'b1;
          last_start_d = 1'b0;
          case (bus.OpCode)
            2'b00:   begin reg_e_d = 1'b1; reg_fun_sel_d = FS_DEC; end
            2'b01:   begin reg_e_d = 1'b1; reg_fun_sel_d = FS_INC; end
            2'b10:   begin reg_e_d = 1'b1; reg_fun_sel_d = FS_CLR; end
            default: reg_e_d = 1'b0;
          endcase
        end
      end

      ST_COLLECT: begin
        if (accept) begin
`ifdef REG_SEQ_TIMEOUT_EN
          stall_d = 8'd0;
`endif
          if (sign_ext_q) begin
            if (cnt_q == 2'd0) begin
              hold_d = bus.ByteIn;
              cnt_d  = 2'd1;
            end else begin
              reg_e_d       = 1'b1;
              reg_fun_sel_d = FS_SEXT;
              reg_i_d       = {16'b0, hold_q, bus.ByteIn};
              state_d       = ST_FLUSH;
              byte_ready_d  = 1'b0;
            end
          end else begin
            reg_e_d       = 1'b1;
            reg_fun_sel_d = (cnt_q == 2'd0) ? FS_LOAD : FS_SHIFT;
            reg_i_d       = {24'b0, bus.ByteIn};
            cnt_d         = cnt_q + 2'd1;
            if (cnt_q == len_q) begin
              state_d      = ST_FLUSH;
              byte_ready_d = 1'b0;
            end
          end
        end
`ifdef REG_SEQ_TIMEOUT_EN
        else if (stall_q == STALL_LIMIT) begin
          err_d        = 1'b1;
          state_d      = ST_IDLE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
        end else begin
          stall_d = stall_q + 8'd1;
        end
`endif
      end

      // Last write is on the bus here; DONE follows so the value is visible with Done.
      ST_FLUSH: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      len_q         <= 2'd0;
      sign_ext_q    <= 1'b0;
      cnt_q         <= 2'd0;
      hold_q        <= 8'd0;
      last_start_q  <= 1'b0;
      byte_ready_q  <= 1'b0;
      op_ack_q      <= 1'b0;
      reg_e_q       <= 1'b0;
      reg_fun_sel_q <= 3'b000;
      reg_i_q       <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef REG_SEQ_TIMEOUT_EN
      stall_q       <= 8'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sign_ext_q    <= sign_ext_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      last_start_q  <= last_start_d;
      byte_ready_q  <= byte_ready_d;
      op_ack_q      <= op_ack_d;
      reg_e_q       <= reg_e_d;
      reg_fun_sel_q <= reg_fun_sel_d;
      reg_i_q       <= reg_i_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef REG_SEQ_TIMEOUT_EN
      stall_q       <= stall_d;
      err_q         <= err_d;
`endif
    end
  end

  assign bus.ByteReady = byte_ready_q;
  assign bus.OpAck     = op_ack_q;
  assign bus.RegE      = reg_e_q;
  assign bus.RegFunSel = reg_fun_sel_q;
  assign bus.RegI      = reg_i_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
`ifdef REG_SEQ_TIMEOUT_EN
  assign bus.Err       = err_q;
`else
  assign bus.Err       = 1'b0;
`endif

endmodule

// File: tb/tb_reg32_load_sequencer.sv
// Directed bench for reg32_load_sequencer with a behavioural FunSel register model.
// The timeout scenario runs only when REG_SEQ_TIMEOUT_EN is defined.
module tb_reg32_load_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   acc;
  int   acc2;
  logic [31:0] reg_model = 32'd0;

  reg32_load_sequencer_if bus ();

  reg32_load_sequencer #(.TIMEOUT(4)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Controlled FunSel register: not reset by the sequencer reset.
  always @(posedge clk) begin
    if (bus.RegE) begin
      case (bus.RegFunSel)
        3'b000:  reg_model <= reg_model - 32'd1;
        3'b001:  reg_model <= reg_model + 32'd1;
        3'b011:  reg_model <= 32'd0;
        3'b100:  reg_model <= bus.RegI;
        3'b110:  reg_model <= {reg_model[23:0], bus.RegI[7:0]};
        3'b111:  reg_model <= {{16{bus.RegI[15]}}, bus.RegI[15:0]};
        default: reg_model <= reg_model;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.Busy),      32'd0);
    check({tag, "_brdy"},  32'(bus.ByteReady), 32'd0);
    check({tag, "_rege"},  32'(bus.RegE),      32'd0);
    check({tag, "_fs"},    32'(bus.RegFunSel), 32'd0);
    check({tag, "_regi"},  bus.RegI,           32'd0);
    check({tag, "_done"},  32'(bus.Done),      32'd0);
    check({tag, "_ack"},   32'(bus.OpAck),     32'd0);
    check({tag, "_err"},   32'(bus.Err),       32'd0);
  endtask

  initial begin
    bus.Start = 1'b0; bus.Len = 2'd0; bus.SignExt = 1'b0; bus.ByteIn = 8'd0;
    bus.ByteValid = 1'b0; bus.OpReq = 1'b0; bus.OpCode = 2'b11;

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Tie after reset: Start wins; OpReq stays high through the load and is never acked
    bus.Start = 1'b1; bus.Len = 2'd3; bus.SignExt = 1'b0;
    bus.OpReq = 1'b1; bus.OpCode = 2'b01;
    tick();
    check("tie1_busy", 32'(bus.Busy), 32'd1);
    check("tie1_ack",  32'(bus.OpAck), 32'd0);
    check("tie1_brdy", 32'(bus.ByteReady), 32'd1);
    bus.Start = 1'b0;
    acc = 1; acc2 = 0;
    bus.ByteValid = 1'b1; bus.ByteIn = 8'h12;
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("b0_rege", 32'(bus.RegE), 32'd1);
    check("b0_fs",   32'(bus.RegFunSel), 32'h4);
    check("b0_regi", bus.RegI, 32'h12);
    bus.ByteIn = 8'h34;
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("b1_fs",   32'(bus.RegFunSel), 32'h6);
    check("b1_regi", bus.RegI, 32'h34);
    bus.ByteIn = 8'h56;
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("b2_fs",   32'(bus.RegFunSel), 32'h6);
    bus.ByteIn = 8'h78;
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("b3_fs",   32'(bus.RegFunSel), 32'h6);
    check("b3_regi", bus.RegI, 32'h78);
    check("b3_brdy", 32'(bus.ByteReady), 32'd0);
    bus.ByteValid = 1'b0;
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("ld4_done", 32'(bus.Done), 32'd1);
    check("ld4_reg",  reg_model, 32'h12345678);
    tick();
    acc += int'(bus.Busy); acc2 += int'(bus.OpAck);
    check("ld4_done_end", 32'(bus.Done), 32'd0);
    check("ld4_busy_cyc", 32'(acc), 32'd6);
    check("busy_no_ack",  32'(acc2), 32'd0);

    // Second tie after DONE: op wins (round-robin)
    bus.Start = 1'b1; bus.Len = 2'd0;
    tick();
    check("tie2_ack",  32'(bus.OpAck), 32'd1);
    check("tie2_busy", 32'(bus.Busy), 32'd0);
    check("tie2_fs",   32'(bus.RegFunSel), 32'h1);
    bus.Start = 1'b0; bus.OpReq = 1'b0;
    tick();
    check("inc_reg", reg_model, 32'h12345679);

    // Clear, then held decrement: one op every other cycle
    bus.OpReq = 1'b1; bus.OpCode = 2'b10;
    tick();
    check("clr_fs", 32'(bus.RegFunSel), 32'h3);
    bus.OpReq = 1'b0;
    tick();
    check("clr_reg", reg_model, 32'h0);
    bus.OpReq = 1'b1; bus.OpCode = 2'b00;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc += int'(bus.OpAck);
    end
    bus.OpReq = 1'b0;
    check("dec_acks", 32'(acc), 32'd3);
    check("dec_reg",  reg_model, 32'hFFFFFFFD);
    tick();

    // No-op: acked without a write
    bus.OpReq = 1'b1; bus.OpCode = 2'b11;
    tick();
    check("nop_ack",  32'(bus.OpAck), 32'd1);
    check("nop_rege", 32'(bus.RegE), 32'd0);
    bus.OpReq = 1'b0;
    tick();
    check("nop_reg", reg_model, 32'hFFFFFFFD);

    // Sign-extended halfword with 3 stall cycles between bytes
    bus.Start = 1'b1; bus.Len = 2'd1; bus.SignExt = 1'b1;
    tick();
    bus.Start = 1'b0; bus.SignExt = 1'b0;
    bus.ByteValid = 1'b1; bus.ByteIn = 8'h80;
    acc = 0;
    tick();
    acc += int'(bus.RegE);
    bus.ByteValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc += int'(bus.RegE);
    end
    bus.ByteValid = 1'b1; bus.ByteIn = 8'h01;
    tick();
    check("sx_fs",   32'(bus.RegFunSel), 32'h7);
    check("sx_regi", bus.RegI, 32'h00008001);
    acc += int'(bus.RegE);
    bus.ByteValid = 1'b0;
    tick();
    acc += int'(bus.RegE);
    check("sx_done", 32'(bus.Done), 32'd1);
    check("sx_reg",  reg_model, 32'hFFFF8001);
    check("sx_rege_cnt", 32'(acc), 32'd1);
    tick();
    check("sx_busy_end", 32'(bus.Busy), 32'd0);

    // Async reset mid-COLLECT after 2 of 4 bytes
    bus.Start = 1'b1; bus.Len = 2'd3;
    tick();
    bus.Start = 1'b0;
    bus.ByteValid = 1'b1; bus.ByteIn = 8'hAA;
    tick();
    bus.ByteIn = 8'hBB;
    tick();
    #3 rst_n = 1'b0;
    #1;
    bus.ByteValid = 1'b0;
    check_all_zero("arst");
    tick();
    check("arst_reg", reg_model, 32'h000000AA);
    rst_n = 1'b1;
    tick();
    bus.Start = 1'b1; bus.Len = 2'd0;
    tick();
    check("post_busy", 32'(bus.Busy), 32'd1);
    bus.Start = 1'b0;
    bus.ByteValid = 1'b1; bus.ByteIn = 8'h5A;
    tick();
    check("post_fs",   32'(bus.RegFunSel), 32'h4);
    check("post_regi", bus.RegI, 32'h5A);
    bus.ByteValid = 1'b0;
    tick();
    check("post_done", 32'(bus.Done), 32'd1);
    check("post_reg",  reg_model, 32'h5A);
    tick();

`ifdef REG_SEQ_TIMEOUT_EN
    // Stall timeout: Err 4 cycles after the last handshake, no Done
    bus.Start = 1'b1; bus.Len = 2'd2;
    tick();
    bus.Start = 1'b0;
    bus.ByteValid = 1'b1; bus.ByteIn = 8'hC3;
    tick();
    bus.ByteValid = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc += int'(bus.Err);
    end
    check("to_early", 32'(acc), 32'd0);
    tick();
    check("to_err",  32'(bus.Err), 32'd1);
    check("to_busy", 32'(bus.Busy), 32'd0);
    check("to_done", 32'(bus.Done), 32'd0);
    tick();
    check("to_err_end", 32'(bus.Err), 32'd0);
    check("to_reg",     reg_model, 32'h000000C3);
`else
    // Without the timeout COLLECT waits indefinitely and Err never rises
    bus.Start = 1'b1; bus.Len = 2'd0;
    tick();
    bus.Start = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc += int'(bus.Err);
    end
    check("nto_err",  32'(acc), 32'd0);
    check("nto_busy", 32'(bus.Busy), 32'd1);
    bus.ByteValid = 1'b1; bus.ByteIn = 8'h3C;
    tick();
    bus.ByteValid = 1'b0;
    tick();
    check("nto_done", 32'(bus.Done), 32'd1);
    check("nto_reg",  reg_model, 32'h3C);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
